// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues icache reads and drives the IF side of IF/ID.
// A redirect that arrives during an icache miss is parked in r_pend_addr until the miss returns.
//
//  state      | meaning
//  -----------+---------------------------------------------------------------
//  ST_RUN     | normal fetch; PC advances on ihit
//  ST_PEND    | redirect taken during a miss; wrong-path data dropped until ihit
//  ST_HALTED  | halt retired; no fetch until nRST
module fetch_unit #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              i_ihit,
  input  logic [WORD_W-1:0] i_iload,
  output logic              o_iREN,
  output logic [WORD_W-1:0] o_iaddr,
  input  logic              i_stall,
  input  logic              i_redirect_valid,
  input  logic [WORD_W-1:0] i_redirect_addr,
  input  logic              i_halt,
  output logic [WORD_W-1:0] o_ifinstr,
  output logic [WORD_W-1:0] o_ifJALjump_addr,
  output logic              o_ifW,
  output logic              o_ifRST
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_pend_addr;

  logic [1:0]        w_next_state;
  logic [WORD_W-1:0] w_next_pc;
  logic [WORD_W-1:0] w_next_pend;
  logic [WORD_W-1:0] w_redir_addr;
  logic [WORD_W-1:0] w_pc_plus4;
  logic              w_iren;
  logic              w_ifw;
  logic              w_ifrst;

  assign w_redir_addr = {i_redirect_addr[WORD_W-1:2], 2'b00};
  assign w_pc_plus4   = r_pc + WORD_W'(4);

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_pend  = r_pend_addr;
    w_iren       = 1'b0;
    w_ifw        = 1'b0;
    w_ifrst      = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_iren = 1'b1;
        if (i_halt) begin
          w_ifw        = 1'b1;
          w_ifrst      = 1'b1;
          w_next_state = ST_HALTED;
        end else if (i_redirect_valid) begin
          w_ifw   = 1'b1;
          w_ifrst = 1'b1;
          // A miss cannot be abandoned, so the target waits in r_pend_addr.
          if (i_ihit) begin
            w_next_pc = w_redir_addr;
          end else begin
            w_next_pend  = w_redir_addr;
            w_next_state = ST_PEND;
          end
        end else if (i_stall) begin
          w_ifw = 1'b0;
        end else if (i_ihit) begin
          w_ifw     = 1'b1;
          w_next_pc = w_pc_plus4;
        end else begin
          w_ifw   = 1'b1;
          w_ifrst = 1'b1;
        end
      end
      ST_PEND: begin
        w_iren = 1'b1;
        if (i_halt) begin
          w_ifw        = 1'b1;
          w_ifrst      = 1'b1;
          w_next_state = ST_HALTED;
        end else begin
          if (i_redirect_valid) begin
            w_next_pend = w_redir_addr;
            w_ifw       = 1'b1;
            w_ifrst     = 1'b1;
          end else if (!i_stall) begin
            w_ifw   = 1'b1;
            w_ifrst = 1'b1;
          end
          if (i_ihit) begin
            w_next_pc    = i_redirect_valid ? w_redir_addr : r_pend_addr;
            w_next_state = ST_RUN;
          end
        end
      end
      ST_HALTED: begin
        w_iren = 1'b0;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_RUN;
      r_pc        <= PC_INIT;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_pend_addr <= w_next_pend;
    end
  end

  // Strobes are gated by nRST so nothing is requested or written while reset is held.
  assign o_iREN           = nRST & w_iren;
  assign o_ifW            = nRST & w_ifw;
  assign o_ifRST          = nRST & w_ifrst;
  assign o_iaddr          = r_pc;
  assign o_ifinstr        = i_iload;
  assign o_ifJALjump_addr = w_pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the continuous main flow,
// plus hand-written sequences for reset, halt, PC wrap and reset during a pending redirect.
module tb_fetch_unit;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        halt;
  logic [31:0] ifinstr;
  logic [31:0] ifJALjump_addr;
  logic        ifW;
  logic        ifRST;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .i_ihit           (ihit),
    .i_iload          (iload),
    .o_iREN           (iREN),
    .o_iaddr          (iaddr),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_addr  (redirect_addr),
    .i_halt           (halt),
    .o_ifinstr        (ifinstr),
    .o_ifJALjump_addr (ifJALjump_addr),
    .o_ifW            (ifW),
    .o_ifRST          (ifRST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ihit;
    logic        stall;
    logic        rv;
    logic [31:0] ra;
    logic        halt;
    logic [31:0] e_iaddr;
    logic        e_w;
    logic        e_rst;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ih, input logic st, input logic rv, input logic [31:0] ra,
                     input logic hl, input logic [31:0] ea, input logic ew, input logic er);
    vec_t v;
    v.ihit = ih; v.stall = st; v.rv = rv; v.ra = ra; v.halt = hl;
    v.e_iaddr = ea; v.e_w = ew; v.e_rst = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ih, input logic st, input logic rv, input logic [31:0] ra,
                       input logic hl);
    ihit = ih; stall = st; redirect_valid = rv; redirect_addr = ra; halt = hl;
  endtask

  initial begin
    // ihit stall rv  ra            halt  exp_iaddr     W  RST
    add(1, 0, 0, 32'h0,          0, 32'h0000_0000, 1, 0);  // fetch i0
    add(1, 0, 0, 32'h0,          0, 32'h0000_0004, 1, 0);  // fetch i1
    add(1, 0, 0, 32'h0,          0, 32'h0000_0008, 1, 0);  // fetch i2
    add(1, 0, 1, 32'h10,         0, 32'h0000_000C, 1, 1);  // jump to 0x10
    add(0, 0, 0, 32'h0,          0, 32'h0000_0010, 1, 1);  // miss x3
    add(0, 0, 0, 32'h0,          0, 32'h0000_0010, 1, 1);
    add(0, 0, 0, 32'h0,          0, 32'h0000_0010, 1, 1);
    add(1, 0, 0, 32'h0,          0, 32'h0000_0010, 1, 0);  // hit -> 0x14
    add(1, 0, 1, 32'h20,         0, 32'h0000_0014, 1, 1);  // jump to 0x20
    add(1, 1, 0, 32'h0,          0, 32'h0000_0020, 0, 0);  // stall x2
    add(1, 1, 0, 32'h0,          0, 32'h0000_0020, 0, 0);
    add(1, 0, 0, 32'h0,          0, 32'h0000_0020, 1, 0);  // release -> 0x24
    add(1, 0, 1, 32'h30,         0, 32'h0000_0024, 1, 1);  // jump to 0x30
    add(0, 0, 0, 32'h0,          0, 32'h0000_0030, 1, 1);  // miss cycle 0
    add(0, 0, 1, 32'h100,        0, 32'h0000_0030, 1, 1);  // redirect 0x100 mid-miss
    add(0, 0, 1, 32'h200,        0, 32'h0000_0030, 1, 1);  // newer redirect 0x200
    add(0, 0, 0, 32'h0,          0, 32'h0000_0030, 1, 1);
    add(1, 0, 0, 32'h0,          0, 32'h0000_0030, 1, 1);  // miss returns, dropped
    add(1, 0, 0, 32'h0,          0, 32'h0000_0200, 1, 0);  // RUN at 0x200
    add(1, 1, 1, 32'h40,         0, 32'h0000_0204, 1, 1);  // redirect beats stall
    add(1, 0, 1, 32'h43,         0, 32'h0000_0040, 1, 1);  // low bits forced to 0
    add(1, 0, 0, 32'h0,          0, 32'h0000_0040, 1, 0);
    add(0, 0, 1, 32'h80,         0, 32'h0000_0044, 1, 1);  // park 0x80
    add(0, 1, 0, 32'h0,          0, 32'h0000_0044, 0, 0);  // stall while pending
    add(1, 1, 0, 32'h0,          0, 32'h0000_0044, 0, 0);  // ihit takes parked addr
    add(0, 0, 0, 32'h0,          0, 32'h0000_0080, 1, 1);  // bubble at 0x80

    drive(0, 0, 0, 32'h0, 0);
    iload = 32'h0;
    nRST  = 1'b0;
    @(negedge CLK);
    ihit = 1'b1;
    #1;
    check("rst iREN",  {31'b0, iREN},  32'h0);
    check("rst ifW",   {31'b0, ifW},   32'h0);
    check("rst ifRST", {31'b0, ifRST}, 32'h0);
    check("rst iaddr", iaddr,          32'h0);
    @(negedge CLK);
    ihit = 1'b0;
    nRST = 1'b1;

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].ihit, vecs[i].stall, vecs[i].rv, vecs[i].ra, vecs[i].halt);
      iload = 32'hA000_0000 + 32'(i);
      #1;
      check($sformatf("v%0d iaddr", i), iaddr, vecs[i].e_iaddr);
      check($sformatf("v%0d ifW", i),   {31'b0, ifW},   {31'b0, vecs[i].e_w});
      check($sformatf("v%0d ifRST", i), {31'b0, ifRST}, {31'b0, vecs[i].e_rst});
      check($sformatf("v%0d iREN", i),  {31'b0, iREN},  32'h1);
      check($sformatf("v%0d jal", i),   ifJALjump_addr, vecs[i].e_iaddr + 32'h4);
      check($sformatf("v%0d instr", i), ifinstr,        32'hA000_0000 + 32'(i));
    end

    // PC wrap at the top of the address space
    @(negedge CLK);
    drive(1, 0, 1, 32'hFFFF_FFFC, 0);
    @(negedge CLK);
    drive(1, 0, 0, 32'h0, 0);
    #1;
    check("wrap iaddr", iaddr,          32'hFFFF_FFFC);
    check("wrap jal",   ifJALjump_addr, 32'h0000_0000);
    @(negedge CLK);
    drive(0, 0, 0, 32'h0, 0);
    #1;
    check("wrap pc", iaddr, 32'h0000_0000);

    // halt at 0xFFFFFFFC: one flush cycle, then frozen
    drive(1, 0, 1, 32'hFFFF_FFFC, 0);
    @(negedge CLK);
    drive(1, 0, 0, 32'h0, 1);
    #1;
    check("halt ifW",   {31'b0, ifW},   32'h1);
    check("halt ifRST", {31'b0, ifRST}, 32'h1);
    check("halt iREN",  {31'b0, iREN},  32'h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      drive(1, k[0], 1, 32'h500, k[1]);
      #1;
      check($sformatf("halted%0d iREN", k),  {31'b0, iREN},  32'h0);
      check($sformatf("halted%0d ifW", k),   {31'b0, ifW},   32'h0);
      check($sformatf("halted%0d ifRST", k), {31'b0, ifRST}, 32'h0);
      check($sformatf("halted%0d iaddr", k), iaddr,          32'hFFFF_FFFC);
    end

    // asynchronous reset mid-cycle leaves HALTED
    #2 nRST = 1'b0;
    #1;
    check("async rst iaddr", iaddr,         32'h0);
    check("async rst iREN",  {31'b0, iREN}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(1, 0, 0, 32'h0, 0);
    #1;
    check("post rst iREN",  {31'b0, iREN},  32'h1);
    check("post rst ifRST", {31'b0, ifRST}, 32'h0);

    // reset while a redirect is pending: the redirect is lost
    @(negedge CLK);
    drive(0, 0, 1, 32'h300, 0);
    @(negedge CLK);
    drive(0, 0, 0, 32'h0, 0);
    #1;
    check("pend iaddr", iaddr, 32'h4);
    #2 nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    drive(1, 0, 0, 32'h0, 0);
    #1;
    check("lost pend ifRST", {31'b0, ifRST}, 32'h0);
    check("lost pend iaddr", iaddr,          32'h0);
    @(negedge CLK);
    drive(0, 0, 0, 32'h0, 0);
    #1;
    check("lost pend next", iaddr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
